// File: rtl/regfile_pkg.sv
// Shared constants and types for the general register file.
//   REG_ZERO / REG_V0 / REG_RA : architectural register indices
//   reg_idx_t                   : register index for the default 32-entry file
//   busy_vec_t                  : one busy bit per register (default size)
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_RA   = 31;

    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    typedef logic [DEF_AW-1:0]   reg_idx_t;
    typedef logic [DEF_NREG-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Ports:
//   addr     : register index read by this port
//   wr_live  : write strobe already qualified against reset
//   wr_addr  : register being written this cycle
//   wr_data  : data being written this cycle
//   mem      : flattened storage, register r at [r*WIDTH +: WIDTH]
//   busy_vec : registered scoreboard, one bit per register
//   data     : read data (zero for register 0, bypassed when enabled)
//   busy     : outstanding-write flag for the addressed register
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic [AW-1:0]         addr,
    input  logic                  wr_live,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [NREG*WIDTH-1:0] mem,
    input  logic [NREG-1:0]       busy_vec,
    output logic [WIDTH-1:0]      data,
    output logic                  busy
);

    logic is_zero;
    logic hit;

    assign is_zero = (addr == AW'(REG_ZERO));
    assign hit     = (BYPASS != 0) && wr_live && (wr_addr == addr) && !is_zero;

    // A bypassed write is the one that retires the pending result, so the
    // busy flag is shown cleared in the same cycle as the forwarded data.
    always_comb begin
        data = mem[addr*WIDTH +: WIDTH];
        busy = busy_vec[addr];
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end else if (hit) begin
            data = wr_data;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS-style general register file with a per-register busy scoreboard.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   rd_addr    : NREAD packed read addresses, port p at [p*AW +: AW]
//   rd_data    : NREAD packed read data, port p at [p*WIDTH +: WIDTH]
//   rd_busy    : per-port outstanding-write flag
//   wr_en, wr_addr, wr_data : single clocked write port
//   pend_set, pend_addr     : mark a register busy (long-latency write issued)
//   v0         : continuous view of register 2, same bypass rule as a read port
//   any_busy   : OR of all registered busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pend_set,
    input  logic [AW-1:0]          pend_addr,
    output logic [WIDTH-1:0]       v0,
    output logic                   any_busy
);

    logic [NREG*WIDTH-1:0] mem;
    logic [NREG-1:0]       busy;
    logic                  wr_live;
    logic                  wr_ok;
    logic                  pend_ok;
    logic                  v0_hit;

    // Forwarding is suppressed while reset is held so every read shows zero.
    assign wr_live = wr_en && !rst;
    assign wr_ok   = wr_en && (wr_addr != AW'(REG_ZERO));
    assign pend_ok = pend_set && (pend_addr != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[wr_addr*WIDTH +: WIDTH] <= wr_data;
        end
    end

    // Set is scheduled after clear so a same-edge pend_set on the register
    // being written leaves it busy (a new long-latency result is on its way).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[wr_addr] <= 1'b0;
            end
            if (pend_ok) begin
                busy[pend_addr] <= 1'b1;
            end
        end
    end

    assign any_busy = |busy;

    assign v0_hit = (BYPASS != 0) && wr_live && (wr_addr == AW'(REG_V0));
    assign v0     = v0_hit ? wr_data : mem[REG_V0*WIDTH +: WIDTH];

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        regfile_rd_port #(
            .WIDTH  (WIDTH),
            .NREG   (NREG),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd_port (
            .addr     (rd_addr[p*AW +: AW]),
            .wr_live  (wr_live),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem      (mem),
            .busy_vec (busy),
            .data     (rd_data[p*WIDTH +: WIDTH]),
            .busy     (rd_busy[p])
        );
    end

endmodule
